// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues sequential fetches with one-deep
// request credit and queues {instruction, address} pairs for the decoder.
module if_prefetch_stage #(
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          INST_W   = 16,
  parameter int unsigned          INC      = 2,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         freeze,
  input  logic                         branch_taken,
  input  logic [ADDR_W-1:0]            branch_addr,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INST_W-1:0]            imem_data,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [INST_W-1:0]            instruction,
  output logic [ADDR_W-1:0]            pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_addr;
  logic              inflight;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [INST_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic              push;
  logic              pop;
  logic [CW:0]       credit;

  // A pending response already owns a queue slot, so it counts against space.
  always_comb begin
    credit      = {1'b0, count} + {{CW{1'b0}}, inflight};
    imem_req    = !rst && !freeze && !branch_taken && (credit < (CW+1)'(DEPTH));
    imem_addr   = fetch_pc;
    push        = !rst && !branch_taken && inflight;
    inst_valid  = (count != '0);
    pop         = !rst && !branch_taken && inst_valid && inst_ready;
    instruction = data_mem[rd_ptr];
    pc          = addr_mem[rd_ptr] + ADDR_W'(INC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (branch_taken) begin
      fetch_pc <= branch_addr;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (imem_req)
        fetch_pc <= fetch_pc + ADDR_W'(INC);
      inflight <= imem_req;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req)
      req_addr <= fetch_pc;
    if (push) begin
      data_mem[wr_ptr] <= imem_data;
      addr_mem[wr_ptr] <= req_addr;
    end
  end

  assert property (@(posedge clk) disable iff (rst) push |-> (count != CW'(DEPTH)));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage; memory returns address*3 one cycle after a request.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [7:0]  branch_addr;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] instruction;
  logic [7:0]  pc;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  if_prefetch_stage #(
    .ADDR_W(8), .INST_W(16), .INC(2), .DEPTH(4), .RESET_PC(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .pc(pc), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    imem_data <= imem_req ? ({8'h00, imem_addr} * 16'd3) : 16'hDEAD;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; inst_ready = 1'b0; branch_addr = 8'h00;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk); #1;
    total++;
    if ({imem_req, inst_valid, count} !== {1'b0, 1'b0, 3'd0})
      $display("FAIL reset_state got req=%b valid=%b count=%0d want 0 0 0", imem_req, inst_valid, count);
    else passed++;
    rst = 1'b0; inst_ready = 1'b1; #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00})
      $display("FAIL reset_first_req got req=%b addr=%h want 1 00", imem_req, imem_addr);
    else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b1; branch_taken = 1'b1; branch_addr = 8'h55; freeze = 1'b1; #1;
    total++;
    if (imem_req !== 1'b0)
      $display("FAIL reset_mid_req got %b want 0", imem_req);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({inst_valid, count} !== {1'b0, 3'd0})
      $display("FAIL reset_mid_clear got valid=%b count=%0d want 0 0", inst_valid, count);
    else passed++;
    rst = 1'b0; branch_taken = 1'b0; freeze = 1'b0; #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00})
      $display("FAIL reset_mid_restart got req=%b addr=%h want 1 00", imem_req, imem_addr);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({inst_valid, count} !== {1'b0, 3'd0})
      $display("FAIL reset_stale_discard got valid=%b count=%0d want 0 0", inst_valid, count);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({inst_valid, pc, instruction} !== {1'b1, 8'h02, 16'h0000})
      $display("FAIL reset_mid_head got valid=%b pc=%h inst=%h want 1 02 0000", inst_valid, pc, instruction);
    else passed++;
  endtask

  task automatic test_sequential();
    apply_reset();
    @(negedge clk); rst = 1'b0; inst_ready = 1'b1; #1;
    total++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 8'h00, 1'b0})
      $display("FAIL seq_c0 got req=%b addr=%h valid=%b want 1 00 0", imem_req, imem_addr, inst_valid);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 8'h02, 1'b0})
      $display("FAIL seq_c1 got req=%b addr=%h valid=%b want 1 02 0", imem_req, imem_addr, inst_valid);
    else passed++;
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk); #1;
      total++;
      if ({inst_valid, pc, instruction, imem_addr} !== {1'b1, 8'(2*(i-1)), 16'(6*(i-2)), 8'(2*i)})
        $display("FAIL seq_c%0d got valid=%b pc=%h inst=%h addr=%h want 1 %h %h %h", i,
                 inst_valid, pc, instruction, imem_addr, 8'(2*(i-1)), 16'(6*(i-2)), 8'(2*i));
      else passed++;
    end
  endtask

  task automatic test_full_and_wrap();
    apply_reset();
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({imem_req, imem_addr} !== {1'b1, 8'(2*i)})
        $display("FAIL full_req%0d got req=%b addr=%h want 1 %h", i, imem_req, imem_addr, 8'(2*i));
      else passed++;
      @(negedge clk); #1;
    end
    total++;
    if (imem_req !== 1'b0)
      $display("FAIL full_c4_req got %b want 0", imem_req);
    else passed++;
    @(negedge clk); #1;
    @(negedge clk); #1;
    total++;
    if ({imem_req, count} !== {1'b0, 3'd4})
      $display("FAIL full_hold got req=%b count=%0d want 0 4", imem_req, count);
    else passed++;
    @(negedge clk); inst_ready = 1'b1; #1;
    total++;
    if ({imem_req, pc, instruction} !== {1'b0, 8'h02, 16'h0000})
      $display("FAIL full_pop got req=%b pc=%h inst=%h want 0 02 0000", imem_req, pc, instruction);
    else passed++;
    @(negedge clk); inst_ready = 1'b0; #1;
    total++;
    if ({imem_req, imem_addr, count} !== {1'b1, 8'h08, 3'd3})
      $display("FAIL full_resume got req=%b addr=%h count=%0d want 1 08 3", imem_req, imem_addr, count);
    else passed++;
    @(negedge clk); inst_ready = 1'b1; #1;
    total++;
    if ({imem_req, count} !== {1'b0, 3'd3})
      $display("FAIL full_pushpop_pre got req=%b count=%0d want 0 3", imem_req, count);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({count, pc, instruction} !== {3'd3, 8'h06, 16'd12})
      $display("FAIL full_pushpop got count=%0d pc=%h inst=%h want 3 06 000c", count, pc, instruction);
    else passed++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      total++;
      if ({inst_valid, pc, instruction} !== {1'b1, 8'(6 + 2*i), 16'(12 + 6*i)})
        $display("FAIL wrap_order%0d got valid=%b pc=%h inst=%h want 1 %h %h", i,
                 inst_valid, pc, instruction, 8'(6 + 2*i), 16'(12 + 6*i));
      else passed++;
    end
  endtask

  task automatic test_branch();
    apply_reset();
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    branch_taken = 1'b1; branch_addr = 8'h40; inst_ready = 1'b1; #1;
    total++;
    if ({imem_req, count} !== {1'b0, 3'd3})
      $display("FAIL br_t got req=%b count=%0d want 0 3", imem_req, count);
    else passed++;
    @(negedge clk); branch_taken = 1'b0; inst_ready = 1'b0; #1;
    total++;
    if ({count, inst_valid, imem_req, imem_addr} !== {3'd0, 1'b0, 1'b1, 8'h40})
      $display("FAIL br_t1 got count=%0d valid=%b req=%b addr=%h want 0 0 1 40", count, inst_valid, imem_req, imem_addr);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({inst_valid, imem_addr} !== {1'b0, 8'h42})
      $display("FAIL br_t2 got valid=%b addr=%h want 0 42", inst_valid, imem_addr);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({inst_valid, pc, instruction, count} !== {1'b1, 8'h42, 16'h00C0, 3'd1})
      $display("FAIL br_t3 got valid=%b pc=%h inst=%h count=%0d want 1 42 00c0 1", inst_valid, pc, instruction, count);
    else passed++;
    @(negedge clk); branch_taken = 1'b1; branch_addr = 8'h80; #1;
    total++;
    if (imem_req !== 1'b0)
      $display("FAIL br_dbl1 got req=%b want 0", imem_req);
    else passed++;
    @(negedge clk); branch_addr = 8'h90; freeze = 1'b1; #1;
    total++;
    if (imem_req !== 1'b0)
      $display("FAIL br_dbl2 got req=%b want 0", imem_req);
    else passed++;
    @(negedge clk); branch_taken = 1'b0; freeze = 1'b0; #1;
    total++;
    if ({imem_req, imem_addr, count} !== {1'b1, 8'h90, 3'd0})
      $display("FAIL br_last_wins got req=%b addr=%h count=%0d want 1 90 0", imem_req, imem_addr, count);
    else passed++;
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    @(negedge clk); rst = 1'b0; inst_ready = 1'b1; branch_taken = 1'b1; branch_addr = 8'hFE; #1;
    total++;
    if (imem_req !== 1'b0)
      $display("FAIL pcw_branch_req got %b want 0", imem_req);
    else passed++;
    @(negedge clk); branch_taken = 1'b0; #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 8'hFE})
      $display("FAIL pcw_fe got req=%b addr=%h want 1 fe", imem_req, imem_addr);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00})
      $display("FAIL pcw_00 got req=%b addr=%h want 1 00", imem_req, imem_addr);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({inst_valid, pc, instruction} !== {1'b1, 8'h00, 16'h02FA})
      $display("FAIL pcw_head got valid=%b pc=%h inst=%h want 1 00 02fa", inst_valid, pc, instruction);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({inst_valid, pc, instruction} !== {1'b1, 8'h02, 16'h0000})
      $display("FAIL pcw_next got valid=%b pc=%h inst=%h want 1 02 0000", inst_valid, pc, instruction);
    else passed++;
  endtask

  task automatic test_freeze();
    apply_reset();
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    freeze = 1'b1; inst_ready = 1'b1; #1;
    total++;
    if ({imem_req, count, pc, instruction} !== {1'b0, 3'd2, 8'h02, 16'h0000})
      $display("FAIL frz_c0 got req=%b count=%0d pc=%h inst=%h want 0 2 02 0000", imem_req, count, pc, instruction);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({imem_req, count, pc, instruction} !== {1'b0, 3'd2, 8'h04, 16'h0006})
      $display("FAIL frz_c1 got req=%b count=%0d pc=%h inst=%h want 0 2 04 0006", imem_req, count, pc, instruction);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({imem_req, count, pc, instruction} !== {1'b0, 3'd1, 8'h06, 16'h000C})
      $display("FAIL frz_c2 got req=%b count=%0d pc=%h inst=%h want 0 1 06 000c", imem_req, count, pc, instruction);
    else passed++;
    @(negedge clk); freeze = 1'b0; #1;
    total++;
    if ({inst_valid, count, imem_req, imem_addr} !== {1'b0, 3'd0, 1'b1, 8'h06})
      $display("FAIL frz_resume got valid=%b count=%0d req=%b addr=%h want 0 0 1 06", inst_valid, count, imem_req, imem_addr);
    else passed++;
    @(negedge clk);
    @(negedge clk); #1;
    total++;
    if ({inst_valid, pc, instruction} !== {1'b1, 8'h08, 16'h0012})
      $display("FAIL frz_after got valid=%b pc=%h inst=%h want 1 08 0012", inst_valid, pc, instruction);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 8'h00; inst_ready = 1'b0;
    test_reset();
    test_sequential();
    test_full_and_wrap();
    test_branch();
    test_pc_wrap();
    test_freeze();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 Parameter ADDR_W, default 8, PC and instruction-memory address width.
REQ-002 Parameter INST_W, default 16, instruction width.
REQ-003 Parameter INC, default 2, PC increment per sequential fetch.
REQ-004 Parameter DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-005 Parameter RESET_PC, default 0, fetch address after reset.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 freeze  in  1  stalls issue of new fetch requests.
REQ-009 branch_taken  in  1  redirect: flush and refetch from branch_addr.
REQ-010 branch_addr  in  ADDR_W  redirect target.
REQ-011 imem_req  out  1  fetch request this cycle.
REQ-012 imem_addr  out  ADDR_W  fetch address, valid while imem_req=1.
REQ-013 imem_data  in  INST_W  memory read data, valid exactly one cycle after imem_req.
REQ-014 inst_valid  out  1  queue head holds an instruction.
REQ-015 inst_ready  in  1  consumer accepts head.
REQ-016 instruction  out  INST_W  head instruction.
REQ-017 pc  out  ADDR_W  head instruction address + INC (next-PC convention).
REQ-018 count  out  clog2(DEPTH+1)  queue occupancy.

Function
REQ-019 fetch_pc register holds next address to request; imem_addr SHALL equal fetch_pc.
REQ-020 imem_req = !rst & !freeze & !branch_taken & (count + inflight < DEPTH); inflight is 1 while a response is pending.
REQ-021 On issue: fetch_pc <= fetch_pc + INC, modulo 2^ADDR_W (wraps, no flag); inflight <= 1; issued address recorded with the request.
REQ-022 Response cycle (inflight=1, no flush): {imem_data, recorded address} pushed at end of that cycle; inst_valid rises next cycle.
REQ-023 Latency: request in cycle t -> inst_valid in cycle t+2 (queue previously empty).
REQ-024 Back-to-back issue allowed: a new request may issue in the same cycle a prior response is captured.
REQ-025 Dequeue when inst_valid & inst_ready; simultaneous push and pop leaves count unchanged.
REQ-026 inst_valid = (count != 0); instruction and pc driven combinationally from head entry; undefined-but-stable when empty.
REQ-027 Read/write pointers wrap modulo DEPTH; credit rule (REQ-020) guarantees no push when full; push-on-full is a design error flagged by assertion.
REQ-028 branch_taken in cycle t: queue cleared (count=0), pending response in t+1 discarded, fetch_pc <= branch_addr, no request in t; first request at t+1 with imem_addr=branch_addr.
REQ-029 branch_taken has priority over freeze and over any same-cycle push/pop; a dequeue handshake in cycle t is void.
REQ-030 freeze: no new request; pending response still captured; queue still drains.
REQ-031 Consecutive branch_taken cycles: last branch_addr wins; no request issued until branch_taken low.

Reset
REQ-032 rst high at a clock edge: fetch_pc=RESET_PC, count=0, pointers=0, inflight=0; response arriving the cycle after reset discarded.
REQ-033 While rst high: imem_req=0, inst_valid=0, count=0; first request in first cycle after rst low with imem_addr=RESET_PC.
REQ-034 Reset mid-operation overrides branch_taken, freeze and handshakes.

Verification
REQ-035 Reset release, inst_ready=1, memory returns addr*3: requests 0,2,4,...; inst_valid from cycle 2; pc=2, instruction=0 then pc=4, instruction=6, one per cycle.
REQ-036 inst_ready=0 from reset, DEPTH=4: exactly 4 requests (0,2,4,6), then imem_req=0, count=4; raising inst_ready resumes requests at 8.
REQ-037 Branch at t to 0x40 with queue holding 3 entries and a pending response: count=0 at t+1, request 0x40 at t+1, inst_valid at t+3 with pc=0x42, stale response never visible.
REQ-038 fetch_pc=0xFE, ADDR_W=8: next request address 0x00; head with address 0xFE reports pc=0x00.
REQ-039 freeze high 3 cycles with a pending request: pending entry pushed, no new requests, drain continues; after freeze low, requests resume at next sequential address.
REQ-040 Simultaneous full-queue pop and response capture at count=3: count stays 3, FIFO order preserved across pointer wrap.
